iob_ram_resp: RTL

IOb native-bus responder backed by an internal word-addressed RAM, with a programmable wait-state counter and a pipelined read-return path. It is the target end of the instruction/data buses driven by the CPU wrapper: it accepts `avalid`/`address`/`wdata`/`wstrb` requests, throttles them with `ready`, and returns read data with a `rvalid` pulse. The SoC uses it as boot/scratch memory and as the bench model of a slow peripheral.

---
 rtl/iob_ram_resp.sv | 122 ++++++++++++
 1 files changed

// File: rtl/iob_ram_resp.sv
// IOb native-bus responder with an internal word RAM, wait-state throttling and a pipelined read return.
// Optional macro IOB_RAM_RESP_RDREG_EN adds an output register on the read path (latency 2 instead of 1).
module iob_ram_resp #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_ADDR_W  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cke_i,
    input  logic                  avalid_i,
    input  logic [ADDR_W-1:0]     address_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  rvalid_o,
    output logic                  ready_o
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  accept;
    logic                  rd_req;
    logic                  wr_req;
    logic [MEM_ADDR_W-1:0] idx;
    logic                  unused_addr;

    logic [DATA_W-1:0]     mem [2**MEM_ADDR_W];

    logic                  rvld_p0;
    logic [DATA_W-1:0]     rdata_p0;

    // Upper address bits alias onto the RAM; byte offset is ignored.
    assign idx         = address_i[MEM_ADDR_W+1:2];
    assign unused_addr = ^{address_i[ADDR_W-1:MEM_ADDR_W+2], address_i[1:0]};

    assign ready_o = cke_i & (state == IDLE);
    assign accept  = avalid_i & ready_o;
    assign wr_req  = accept & (|wstrb_i);
    assign rd_req  = accept & ~(|wstrb_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else if (cke_i) begin
            case (state)
                IDLE: begin
                    if (accept && WS != 4'd0) begin
                        cnt   <= WS;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd1) begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    cnt   <= 4'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_req) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wstrb_i[b]) begin
                    mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Stage p0: RAM read register, loaded only on an accepted read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvld_p0  <= 1'b0;
            rdata_p0 <= '0;
        end else if (cke_i) begin
            rvld_p0 <= rd_req;
            if (rd_req) begin
                rdata_p0 <= mem[idx];
            end
        end
    end

`ifdef IOB_RAM_RESP_RDREG_EN
    logic              rvld_p1;
    logic [DATA_W-1:0] rdata_p1;

    // Stage p1: output register; captures p0 only when p0 holds a fresh word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvld_p1  <= 1'b0;
            rdata_p1 <= '0;
        end else if (cke_i) begin
            rvld_p1 <= rvld_p0;
            if (rvld_p0) begin
                rdata_p1 <= rdata_p0;
            end
        end
    end

    assign rvalid_o = rvld_p1;
    assign rdata_o  = rdata_p1;
`else
    assign rvalid_o = rvld_p0;
    assign rdata_o  = rdata_p0;
`endif

endmodule
